// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point widths, FSM states and result record
package fp_pkg;

  localparam int EXP_W  = 4;
  localparam int FRAC_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SHIFT,
    ST_DONE
  } norm_state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-2:0] frac;
    logic              zero;
    logic              overflow;
    logic              underflow;
  } fp_result_t;

endpackage

// File: rtl/normalize_f.sv
// rtl/normalize_f.sv - post-add normalizer: carry fix-up, one-bit-per-cycle left shift, flags
module normalize_f #(
  parameter int EXP_W  = fp_pkg::EXP_W,
  parameter int FRAC_W = fp_pkg::FRAC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic              carry_in,
  input  logic [FRAC_W-1:0] mag_in,
  output logic              busy,
  output logic              done,
  output logic              sum_s,
  output logic [EXP_W-1:0]  sum_e,
  output logic [FRAC_W-2:0] sum_f,
  output logic              zero,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  fp_pkg::norm_state_e state_q;

  logic              sign_q;
  logic              carry_q;
  logic [EXP_W-1:0]  exp_q;
  logic [FRAC_W-1:0] mag_q;

  logic              busy_q;
  logic              done_q;
  logic              sum_s_q;
  logic [EXP_W-1:0]  sum_e_q;
  logic [FRAC_W-2:0] sum_f_q;
  logic              zero_q;
  logic              ovf_q;
  logic              udf_q;

  logic [FRAC_W-1:0] mag_shl;
  logic [FRAC_W-1:0] mag_rsh;

  logic              fin_d;
  logic              res_s_d;
  logic [EXP_W-1:0]  res_e_d;
  logic [FRAC_W-2:0] res_f_d;
  logic              res_zero_d;
  logic              res_ovf_d;
  logic              res_udf_d;

  assign mag_shl = {mag_q[FRAC_W-2:0], 1'b0};
  assign mag_rsh = {1'b1, mag_q[FRAC_W-1:1]};

  // Result that would be latched if this cycle finishes the operation.
  always_comb begin
    fin_d      = 1'b0;
    res_s_d    = sign_q;
    res_e_d    = exp_q;
    res_f_d    = mag_q[FRAC_W-2:0];
    res_zero_d = 1'b0;
    res_ovf_d  = 1'b0;
    res_udf_d  = 1'b0;
    case (state_q)
      fp_pkg::ST_CHECK: begin
        fin_d = carry_q || (mag_q == '0) || mag_q[FRAC_W-1];
        if (carry_q && (exp_q == EXP_MAX)) begin
          res_ovf_d = 1'b1;
          res_e_d   = EXP_MAX;
          res_f_d   = '1;
        end else if (carry_q) begin
          res_e_d = exp_q + 1'b1;
          res_f_d = mag_rsh[FRAC_W-2:0];
        end else if (mag_q == '0) begin
          res_zero_d = 1'b1;
          res_s_d    = 1'b0;
          res_e_d    = '0;
          res_f_d    = '0;
        end
      end
      fp_pkg::ST_SHIFT: begin
        if (exp_q == '0) begin
          fin_d     = 1'b1;
          res_udf_d = 1'b1;
          res_s_d   = 1'b0;
          res_e_d   = '0;
          res_f_d   = '0;
        end else begin
          fin_d   = mag_shl[FRAC_W-1];
          res_e_d = exp_q - 1'b1;
          res_f_d = mag_shl[FRAC_W-2:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= fp_pkg::ST_IDLE;
      sign_q  <= 1'b0;
      carry_q <= 1'b0;
      exp_q   <= '0;
      mag_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_s_q <= 1'b0;
      sum_e_q <= '0;
      sum_f_q <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (fin_d) begin
        state_q <= fp_pkg::ST_DONE;
        done_q  <= 1'b1;
        sum_s_q <= res_s_d;
        sum_e_q <= res_e_d;
        sum_f_q <= res_f_d;
        zero_q  <= res_zero_d;
        ovf_q   <= res_ovf_d;
        udf_q   <= res_udf_d;
      end
      case (state_q)
        fp_pkg::ST_IDLE: begin
          if (start) begin
            sign_q  <= sign_in;
            exp_q   <= exp_in;
            carry_q <= carry_in;
            mag_q   <= mag_in;
            busy_q  <= 1'b1;
            state_q <= fp_pkg::ST_CHECK;
          end
        end
        fp_pkg::ST_CHECK: begin
          if (carry_q && (exp_q != EXP_MAX)) begin
            mag_q <= mag_rsh;
            exp_q <= exp_q + 1'b1;
          end else if (!fin_d) begin
            state_q <= fp_pkg::ST_SHIFT;
          end
        end
        fp_pkg::ST_SHIFT: begin
          if (exp_q != '0) begin
            mag_q <= mag_shl;
            exp_q <= exp_q - 1'b1;
          end
        end
        fp_pkg::ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= fp_pkg::ST_IDLE;
        end
        default: state_q <= fp_pkg::ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum_s     = sum_s_q;
  assign sum_e     = sum_e_q;
  assign sum_f     = sum_f_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: doc/normalize_f.md
NORMALIZE_F -- requirements
Module: normalize_f

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): EXP_W, 4, exponent width; FRAC_W, 6, magnitude width including the hidden bit.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- sign_in  in  1  result sign from the add/sub stage.
- exp_in  in  EXP_W  exponent of the larger operand.
- carry_in  in  1  carry out of the fraction add.
- mag_in  in  FRAC_W  un-normalized magnitude (mag_f).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; the result is valid.
- sum_s  out  1  result sign.
- sum_e  out  EXP_W  result exponent.
- sum_f  out  FRAC_W-1  result fraction, hidden bit dropped.
- zero  out  1  the result is exactly zero.
- overflow  out  1  the exponent saturated.
- underflow  out  1  the result was flushed to zero.

Function
REQ-003 The FSM SHALL have four states, IDLE, CHECK, SHIFT and DONE, with registered state.
REQ-004 In IDLE, start=1 SHALL capture sign_in, exp_in, carry_in and mag_in into working registers and go to CHECK; start=0 SHALL stay in IDLE.
REQ-005 start SHALL be ignored while busy=1, and the working registers SHALL NOT change on it.
REQ-006 CHECK, carry=1, exp<max: the magnitude SHALL become {1,mag[FRAC_W-1:1]} (LSB truncated), exp SHALL increment, and the FSM SHALL go to DONE.
REQ-007 CHECK, carry=1, exp=max: overflow SHALL be set, with sum_e=max and sum_f all ones; go to DONE.
REQ-008 CHECK, carry=0, mag=0: zero SHALL be set, with sum_s=0, sum_e=0 and sum_f=0; go to DONE.
REQ-009 CHECK, carry=0, mag MSB=1: the FSM SHALL go to DONE with mag and exp unchanged.
REQ-010 CHECK, carry=0, mag nonzero, mag MSB=0: the FSM SHALL go to SHIFT.
REQ-011 SHIFT, exp=0: underflow SHALL be set, the result SHALL be flushed to zero (sum_s=0, sum_e=0, sum_f=0), and the FSM SHALL go to DONE.
REQ-012 SHIFT, exp>0: the block SHALL shift mag left by 1 and decrement exp, once per cycle. It SHALL go to DONE when the shifted MSB=1 and otherwise stay in SHIFT.
REQ-013 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-014 Latency SHALL be 2+k cycles from the start-sampling edge to done, where k = number of SHIFT cycles. The maximum k is FRAC_W-1 for the default parameters without underflow, giving 7 cycles.
REQ-015 sum_s, sum_e, sum_f, zero, overflow and underflow SHALL be registered outputs.
- They SHALL update on entry to DONE and hold until the next done.
- The flags SHALL be mutually exclusive.
REQ-016 sum_f SHALL equal mag[FRAC_W-2:0] of the final working magnitude.
REQ-017 sum_s SHALL equal the captured sign except where REQ-008 or REQ-011 forces 0.

Reset
REQ-018 reset=1 SHALL asynchronously force state=IDLE and clear all working registers, and SHALL hold every output at 0 (busy, done, sum_s, sum_e, sum_f, zero, overflow, underflow).
REQ-019 reset asserted mid-operation SHALL abort the operation with no done pulse. The first start after deassertion SHALL be processed normally.

Structure
REQ-020 A shared package fp_pkg SHALL hold EXP_W, FRAC_W, the FSM state enum, and a result struct (sign, exp, frac, flags) reused by the adjacent add/sub stages.
REQ-021 normalize_f SHALL be a single module with no sub-modules; the per-cycle shifter is inline.

Verification
REQ-022 The bench SHALL cover these scenarios:
- sign=1, exp=5, carry=0, mag=100000 -> done at +2, sum_s=1, sum_e=5, sum_f=00000, no flags.
- exp=8, carry=0, mag=000101 -> 3 shifts, done at +5, sum_e=5, sum_f=01000.
- exp=3, carry=1, mag=010110 -> done at +2, sum_e=4, sum_f=01011.
- mag=0, carry=0, sign=1 -> done at +2, zero=1, sum_s=0, sum_e=0.
- Boundary flags:
  - exp=15, carry=1 -> overflow=1, sum_e=15, sum_f=11111.
  - exp=1, mag=000011 -> underflow=1, all zero, done at +4.
- start pulsed again while busy -> ignored, first result intact. Then reset asserted in SHIFT -> IDLE, no done; the next start produces a correct result.
